led_blink_1hz: RTL and testbench

//  Free-running LED blinker for the board top level. Divides the system clock
//  by 2*half_freq and drives a square wave on LED. The default parameters give
//  1 Hz with 50 % duty on a 125 MHz clock. Pure leaf block: no handshakes and
//  no other inputs.

---
 rtl/led_blink_1hz.sv | 59 +++++
 tb/tb_led_blink_1hz.sv | 104 ++++++++++
 2 files changed

// File: rtl/led_blink_1hz.sv
// ---------------------------------------------------------------------------
// led_blink_1hz
//   Free-running LED blinker. It divides clk by 2*half_freq and drives a
//   square wave with exactly 50 % duty on LED. With the defaults this gives
//   1 Hz on a 125 MHz clock.
//
// Parameters
//   half_freq  clock cycles per LED half-period; must be >= 1
//   W          counter width; must satisfy 2**W >= half_freq
//
// Ports
//   clk      in   system clock, rising edge
//   rst_btn  in   asynchronous active-high reset (push-button)
//   LED      out  blink output, driven directly from a flop
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module led_blink_1hz #(
   parameter int half_freq = 62_500_000,
   parameter int W         = 26
) (
   input  logic clk,
   input  logic rst_btn,
   output logic LED
);

   // Terminal count, truncated to the counter width.
   localparam logic [W-1:0] C_TERM = W'(half_freq - 1);

   // Elaboration-time guard: the counter must be able to hold half_freq-1.
   if ((longint'(1) << W) < longint'(half_freq)) begin : g_w_chk
      $error("led_blink_1hz: 2**W (W=%0d) is smaller than half_freq=%0d", W, half_freq);
   end
   if (half_freq < 1) begin : g_hf_chk
      $error("led_blink_1hz: half_freq must be >= 1 (got %0d)", half_freq);
   end

   // Declaration initialisers keep the output defined before any reset.
   logic [W-1:0] r_cnt = '0;
   logic         r_led = 1'b0;
   logic         w_term;

   // Equality compare: the counter never runs past C_TERM, so it never wraps.
   assign w_term = (r_cnt == C_TERM);

   always_ff @(posedge clk or posedge rst_btn) begin
      if (rst_btn) begin
         r_cnt <= '0;
         r_led <= 1'b0;
      end else if (w_term) begin
         r_cnt <= '0;
         r_led <= ~r_led;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign LED = r_led;

endmodule

// File: tb/tb_led_blink_1hz.sv
`timescale 1ns/1ps
module tb_led_blink_1hz;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic rst2 = 1'b1;
   logic led;
   logic led2;

   int n_chk = 0;
   int n_bad = 0;

   always #4 clk = ~clk;   // rising edges at 4 + 8k ns

   led_blink_1hz #(.half_freq(10), .W(4)) u_dut (
      .clk     (clk),
      .rst_btn (rst),
      .LED     (led)
   );

   led_blink_1hz #(.half_freq(1), .W(1)) u_dut1 (
      .clk     (clk),
      .rst_btn (rst2),
      .LED     (led2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic at(input int t);
      #(t - int'($time));
   endtask

   longint last_t;
   logic   prev;

   initial begin
      // 1. power-up, no reset
      at(1);    chk("pu_led0",   32'(led), 0);
      chk("pu_cnt0", 32'(u_dut.r_cnt), 0);
      at(75);   chk("pu_pre",    32'(led), 0);
      at(77);   chk("pu_tgl",    32'(led), 1);
      chk("pu_cnt_wrap", 32'(u_dut.r_cnt), 0);
      at(99);   chk("pu_hold",   32'(led), 1);

      // 2. reset window
      at(100);  rst = 1'b1;
      at(101);  chk("rst_led",   32'(led), 0);
      chk("rst_cnt", 32'(u_dut.r_cnt), 0);
      at(150);  chk("rst_hold_led", 32'(led), 0);
      chk("rst_hold_cnt", 32'(u_dut.r_cnt), 0);
      at(199);  chk("rst_end_led",  32'(led), 0);

      // 3. release and first toggles
      at(200);  rst = 1'b0;
      at(205);  chk("rel_cnt1",  32'(u_dut.r_cnt), 1);
      at(275);  chk("t1_pre",    32'(led), 0);
      at(277);  chk("t1_post",   32'(led), 1);
      at(355);  chk("t2_pre",    32'(led), 1);
      at(357);  chk("t2_post",   32'(led), 0);
      at(435);  chk("t3_pre",    32'(led), 0);
      at(437);  chk("t3_post",   32'(led), 1);

      // 4. steady-state intervals and counter range up to 1200 ns
      last_t = 0;
      prev   = led;
      while ($time < 1200) begin
         @(negedge clk);
         chk("cnt_rng", 32'(u_dut.r_cnt <= 4'd9), 1);
         if (led !== prev) begin
            if (last_t != 0) chk("ivl", 32'($time - last_t), 80);
            last_t = $time;
            prev   = led;
         end
      end

      // 5. reset pulse in the middle of a high phase, between clock edges
      at(1261); chk("mid_hi",    32'(led), 1);
      at(1262); rst = 1'b1;
      at(1263); chk("mid_rst_led", 32'(led), 0);
      chk("mid_rst_cnt", 32'(u_dut.r_cnt), 0);
      at(1282); rst = 1'b0;
      at(1355); chk("mid_pre",   32'(led), 0);
      at(1357); chk("mid_post",  32'(led), 1);

      // 6. half_freq=1: toggle on every rising edge
      chk("hf1_rst", 32'(led2), 0);
      at(1402); rst2 = 1'b0;
      at(1403); chk("hf1_pre", 32'(led2), 0);
      for (int k = 0; k < 6; k++) begin
         at(1405 + 8 * k);
         chk("hf1_tgl", 32'(led2), 32'((k + 1) % 2));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
